regs_wb_sched: RTL and testbench
================================

// Module: regs_wb_sched
// PURPOSE
// Writeback scheduler for the single write port of the 32x32 register file.
// Arbitrates between EX (ALU) results and LSU (load) results, and buffers load
// results in a DEPTH-entry FIFO. Keeps a load-pending scoreboard so ID can stall
// on RAW/WAW hazards. Sits between EX/LSU and the register file write port.
// PARAMETERS
// DEPTH  2   LSU result FIFO depth (>=1)
// XLEN   32  data width
// PORTS
// clk           in   1                 clock, all state updates on posedge
// rst           in   1                 reset, synchronous, active-low
// ex_valid_i    in   1                 EX has a writeback
// ex_ready_o    out  1                 EX writeback accepted this cycle
// ex_waddr_i    in   5                 EX destination register
// ex_wdata_i    in   XLEN              EX result
// lsu_valid_i   in   1                 LSU has load data
// lsu_ready_o   out  1                 FIFO can accept load data
// lsu_waddr_i   in   5                 load destination register
// lsu_wdata_i   in   XLEN              load data
// ld_issue_i    in   1                 load issued; mark ld_rd_i pending
// ld_rd_i       in   5                 issued load destination
// id_rs1_i      in   5                 ID source register 1
// id_rs2_i      in   5                 ID source register 2
// id_stall_o    out  1                 ID must hold: a source is load-pending
// reg_wen_o     out  1                 register file write enable (registered)
// reg_waddr_o   out  5                 register file write address (registered)
// reg_wdata_o   out  XLEN              register file write data (registered)
// buf_count_o   out  $clog2(DEPTH+1)   FIFO occupancy
// err_o         out  1                 sticky protocol error
// BEHAVIOUR
// - Reset (rst==0 at posedge): FIFO empty, busy[31:0]=0, reg_wen_o/waddr/wdata=0,
//   err_o=0. ex_ready_o and lsu_ready_o are forced 0 while rst==0. In-flight data dropped.
// - lsu_ready_o = (count<DEPTH). No same-cycle pass-through on pop.
//   Enqueue on lsu_valid_i&&lsu_ready_o.
// - Port select each cycle: FIFO head has priority (older instruction). When count>0,
//   pop the head and load the output regs. Otherwise, when EX is accepted, load the
//   output regs from EX. Otherwise reg_wen_o<=0.
// - ex_ready_o = rst && count==0 && !(ex_waddr_i!=0 && busy[ex_waddr_i]). A WAW on a
//   pending load holds EX until that load retires.
// - Latency: EX accept at edge N -> reg_wen_o high after edge N. LSU enqueue at edge N
//   -> reg_wen_o high after edge N+1 at the earliest.
// - x0: writes to address 0 are accepted/popped normally, but reg_wen_o<=0.
// - Scoreboard: busy[r] is set on ld_issue_i && ld_rd_i!=0. It is cleared when a FIFO
//   entry with waddr r is popped. Same-cycle set and clear of the same r: set wins.
//   busy[0] is always 0.
// - id_stall_o = (id_rs1_i!=0 && busy[id_rs1_i]) || (id_rs2_i!=0 && busy[id_rs2_i]).
//   Combinational.
// - err_o is set (sticky until reset) on either:
//   - ld_issue_i to an already-busy nonzero rd;
//   - an enqueue whose lsu_waddr_i!=0 and busy[lsu_waddr_i]==0.
//   Both operations still complete.
// - Push and pop in the same cycle: count unchanged, FIFO pointers wrap modulo DEPTH.
// - buf_count_o = count, registered.
// TESTING
// 1 EX only: ex_valid, waddr=5, wdata=0xDEAD_BEEF, empty FIFO -> ex_ready=1;
//   next cycle reg_wen=1, waddr=5, wdata=0xDEADBEEF.
// 2 Load path: ld_issue rd=7 -> busy[7]; id_rs2=7 -> id_stall=1. lsu enqueue
//   (7, 0x1234) -> write 2 cycles later; stall drops after the pop edge.
// 3 Contention: FIFO has 1 entry and EX valid -> ex_ready=0. Head written first;
//   EX written the following cycle.
// 4 FIFO full (DEPTH=2, 2 loads) -> lsu_ready=0. Sustained push+pop for 8 cycles
//   -> count stable, order preserved.
// 5 x0 and WAW: EX waddr=0 -> accepted, reg_wen=0. EX waddr=9 while busy[9]
//   -> ex_ready=0 until load 9 retires.
// 6 Errors/reset: double ld_issue rd=3 -> err_o=1. rst=0 mid-traffic -> all outputs
//   0, count=0, busy cleared.

Source files
------------

// File: rtl/regs_wb_sched.sv
// Writeback scheduler for the register file write port: arbitrates EX results against
// buffered load results and tracks load-pending destinations for ID hazard stalls.
module regs_wb_sched #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic [4:0]                 ex_waddr_i,
    input  logic [XLEN-1:0]            ex_wdata_i,
    input  logic                       lsu_valid_i,
    output logic                       lsu_ready_o,
    input  logic [4:0]                 lsu_waddr_i,
    input  logic [XLEN-1:0]            lsu_wdata_i,
    input  logic                       ld_issue_i,
    input  logic [4:0]                 ld_rd_i,
    input  logic [4:0]                 id_rs1_i,
    input  logic [4:0]                 id_rs2_i,
    output logic                       id_stall_o,
    output logic                       reg_wen_o,
    output logic [4:0]                 reg_waddr_o,
    output logic [XLEN-1:0]            reg_wdata_o,
    output logic [$clog2(DEPTH+1)-1:0] buf_count_o,
    output logic                       err_o
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 2 ** PW;

    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [4:0]      fifo_addr [SLOTS];
    logic [XLEN-1:0] fifo_data [SLOTS];
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [4:0]      head_addr;
    logic [XLEN-1:0] head_data;
    logic            push;
    logic            pop;
    logic            ex_acc;
    logic            ex_hazard;
    logic            err_set;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes, hazard detection and scoreboard next-state
    always_comb begin
        head_addr   = fifo_addr[rd_ptr];
        head_data   = fifo_data[rd_ptr];
        lsu_ready_o = rst && (count < CW'(DEPTH));
        pop         = rst && (count != '0);
        push        = lsu_valid_i && lsu_ready_o;
        ex_hazard   = (ex_waddr_i != 5'd0) && busy[ex_waddr_i];
        ex_ready_o  = rst && (count == '0) && !ex_hazard;
        ex_acc      = ex_valid_i && ex_ready_o;
        id_stall_o  = ((id_rs1_i != 5'd0) && busy[id_rs1_i]) ||
                      ((id_rs2_i != 5'd0) && busy[id_rs2_i]);
        err_set     = (ld_issue_i && (ld_rd_i != 5'd0) && busy[ld_rd_i]) ||
                      (push && (lsu_waddr_i != 5'd0) && !busy[lsu_waddr_i]);
        // a retiring load and a new issue to the same rd leave it pending
        busy_nxt = busy;
        if (pop) busy_nxt[head_addr] = 1'b0;
        if (ld_issue_i) busy_nxt[ld_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Load-result storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= lsu_waddr_i;
            fifo_data[wr_ptr] <= lsu_wdata_i;
        end
    end

    // Control state and registered write port; FIFO head wins over EX
    always_ff @(posedge clk) begin
        if (!rst) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            busy        <= '0;
            err_o       <= 1'b0;
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_wdata_o <= '0;
        end else begin
            busy <= busy_nxt;
            if (err_set) err_o <= 1'b1;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            if (pop) begin
                reg_wen_o   <= (head_addr != 5'd0);
                reg_waddr_o <= head_addr;
                reg_wdata_o <= head_data;
            end else if (ex_acc) begin
                reg_wen_o   <= (ex_waddr_i != 5'd0);
                reg_waddr_o <= ex_waddr_i;
                reg_wdata_o <= ex_wdata_i;
            end else begin
                reg_wen_o <= 1'b0;
            end
        end
    end

    assign buf_count_o = count;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Directed bench for regs_wb_sched; a DEPTH=1 copy shares the stimulus to exercise the full-FIFO case.
module tb_regs_wb_sched;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        lsu_valid;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;

    logic        ex_ready, lsu_ready, id_stall, reg_wen, err;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [1:0]  buf_count;

    logic        d1_ex_ready, d1_lsu_ready, d1_id_stall, d1_reg_wen, d1_err;
    logic [4:0]  d1_reg_waddr;
    logic [31:0] d1_reg_wdata;
    logic [0:0]  d1_buf_count;

    int n_chk;
    int n_fail;

    regs_wb_sched #(.DEPTH(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .ld_issue_i(ld_issue), .ld_rd_i(ld_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_stall_o(id_stall), .reg_wen_o(reg_wen), .reg_waddr_o(reg_waddr), .reg_wdata_o(reg_wdata),
        .buf_count_o(buf_count), .err_o(err)
    );

    regs_wb_sched #(.DEPTH(1), .XLEN(32)) u_d1 (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid), .ex_ready_o(d1_ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(d1_lsu_ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .ld_issue_i(ld_issue), .ld_rd_i(ld_rd), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_stall_o(d1_id_stall), .reg_wen_o(d1_reg_wen), .reg_waddr_o(d1_reg_waddr), .reg_wdata_o(d1_reg_wdata),
        .buf_count_o(d1_buf_count), .err_o(d1_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0;
        lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
        ld_issue = 0; ld_rd = 0; id_rs1 = 0; id_rs2 = 0;
        @(negedge clk); @(negedge clk);
        n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %0h, expected 0", reg_wen); end
        n_chk++; if (reg_waddr !== 5'd0) begin n_fail++; $display("FAIL rst_waddr: got %0h, expected 0", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata: got %0h, expected 0", reg_wdata); end
        n_chk++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL rst_count: got %0h, expected 0", buf_count); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h, expected 0", err); end
        n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ex_ready: got %0h, expected 0", ex_ready); end
        n_chk++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lsu_ready: got %0h, expected 0", lsu_ready); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ex_only();
        ex_valid = 1; ex_waddr = 5; ex_wdata = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL ex_ready: got %0h, expected 1", ex_ready); end
        @(negedge clk);
        ex_valid = 0;
        n_chk++; if (reg_wen !== 1'b1) begin n_fail++; $display("FAIL ex_wen: got %0h, expected 1", reg_wen); end
        n_chk++; if (reg_waddr !== 5'd5) begin n_fail++; $display("FAIL ex_waddr: got %0h, expected 5", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ex_wdata: got %0h, expected deadbeef", reg_wdata); end
        @(negedge clk);
        n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL ex_wen_drop: got %0h, expected 0", reg_wen); end
    endtask

    task automatic test_load_path();
        ld_issue = 1; ld_rd = 7; id_rs2 = 7;
        #1;
        n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall_pre: got %0h, expected 0", id_stall); end
        @(negedge clk);
        ld_issue = 0;
        #1;
        n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_busy: got %0h, expected 1", id_stall); end
        lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h1234;
        #1;
        n_chk++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL ld_lsu_ready: got %0h, expected 1", lsu_ready); end
        @(negedge clk);
        lsu_valid = 0;
        n_chk++; if (buf_count !== 2'd1) begin n_fail++; $display("FAIL ld_count: got %0h, expected 1", buf_count); end
        n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL ld_wen_early: got %0h, expected 0", reg_wen); end
        n_chk++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_queued: got %0h, expected 1", id_stall); end
        @(negedge clk);
        n_chk++; if (reg_wen !== 1'b1) begin n_fail++; $display("FAIL ld_wen: got %0h, expected 1", reg_wen); end
        n_chk++; if (reg_waddr !== 5'd7) begin n_fail++; $display("FAIL ld_waddr: got %0h, expected 7", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'h1234) begin n_fail++; $display("FAIL ld_wdata: got %0h, expected 1234", reg_wdata); end
        n_chk++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL ld_count_pop: got %0h, expected 0", buf_count); end
        n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL ld_stall_clear: got %0h, expected 0", id_stall); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL ld_err: got %0h, expected 0", err); end
        id_rs2 = 0;
    endtask

    task automatic test_contention();
        ld_issue = 1; ld_rd = 4;
        @(negedge clk);
        ld_issue = 0;
        lsu_valid = 1; lsu_waddr = 4; lsu_wdata = 32'hAAAA;
        @(negedge clk);
        lsu_valid = 0;
        ex_valid = 1; ex_waddr = 6; ex_wdata = 32'h6666;
        #1;
        n_chk++; if (buf_count !== 2'd1) begin n_fail++; $display("FAIL ct_count: got %0h, expected 1", buf_count); end
        n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL ct_ex_blocked: got %0h, expected 0", ex_ready); end
        @(negedge clk);
        n_chk++; if (reg_waddr !== 5'd4) begin n_fail++; $display("FAIL ct_head_waddr: got %0h, expected 4", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'hAAAA) begin n_fail++; $display("FAIL ct_head_wdata: got %0h, expected aaaa", reg_wdata); end
        #1;
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL ct_ex_ready: got %0h, expected 1", ex_ready); end
        @(negedge clk);
        ex_valid = 0;
        n_chk++; if (reg_wen !== 1'b1) begin n_fail++; $display("FAIL ct_ex_wen: got %0h, expected 1", reg_wen); end
        n_chk++; if (reg_waddr !== 5'd6) begin n_fail++; $display("FAIL ct_ex_waddr: got %0h, expected 6", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'h6666) begin n_fail++; $display("FAIL ct_ex_wdata: got %0h, expected 6666", reg_wdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            ld_issue = 1; ld_rd = 5'(16 + i);
            @(negedge clk);
        end
        ld_issue = 0;
        for (int i = 0; i < 8; i++) begin
            lsu_valid = 1; lsu_waddr = 5'(16 + i); lsu_wdata = 32'h100 + 32'(i);
            #1;
            n_chk++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_lsu_ready[%0d]: got %0h, expected 1", i, lsu_ready); end
            if (i == 0) begin
                n_chk++; if (d1_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL d1_ready_empty: got %0h, expected 1", d1_lsu_ready); end
            end
            @(negedge clk);
            if (i == 0) begin
                n_chk++; if (d1_lsu_ready !== 1'b0) begin n_fail++; $display("FAIL d1_ready_full: got %0h, expected 0", d1_lsu_ready); end
                n_chk++; if (d1_buf_count !== 1'b1) begin n_fail++; $display("FAIL d1_count_full: got %0h, expected 1", d1_buf_count); end
            end
            n_chk++; if (buf_count !== 2'd1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0h, expected 1", i, buf_count); end
            if (i > 0) begin
                n_chk++; if (reg_waddr !== 5'(15 + i)) begin n_fail++; $display("FAIL b2b_waddr[%0d]: got %0h, expected %0h", i, reg_waddr, 15 + i); end
                n_chk++; if (reg_wdata !== 32'hFF + 32'(i)) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %0h, expected %0h", i, reg_wdata, 32'hFF + i); end
            end
        end
        lsu_valid = 0;
        @(negedge clk);
        id_rs1 = 23;
        #1;
        n_chk++; if (reg_waddr !== 5'd23) begin n_fail++; $display("FAIL b2b_last_waddr: got %0h, expected 17", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'h107) begin n_fail++; $display("FAIL b2b_last_wdata: got %0h, expected 107", reg_wdata); end
        n_chk++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL b2b_drain: got %0h, expected 0", buf_count); end
        n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got %0h, expected 0", id_stall); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %0h, expected 0", err); end
        id_rs1 = 0;
    endtask

    task automatic test_x0_waw();
        ex_valid = 1; ex_waddr = 0; ex_wdata = 32'h55;
        #1;
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0h, expected 1", ex_ready); end
        @(negedge clk);
        ex_valid = 0;
        n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen: got %0h, expected 0", reg_wen); end
        ld_issue = 1; ld_rd = 9;
        @(negedge clk);
        ld_issue = 0;
        ex_valid = 1; ex_waddr = 9; ex_wdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL waw_hold[%0d]: got %0h, expected 0", i, ex_ready); end
            @(negedge clk);
            n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL waw_wen[%0d]: got %0h, expected 0", i, reg_wen); end
        end
        lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'h900;
        @(negedge clk);
        lsu_valid = 0;
        #1;
        n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL waw_queued: got %0h, expected 0", ex_ready); end
        @(negedge clk);
        n_chk++; if (reg_wdata !== 32'h900) begin n_fail++; $display("FAIL waw_load_data: got %0h, expected 900", reg_wdata); end
        #1;
        n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %0h, expected 1", ex_ready); end
        @(negedge clk);
        ex_valid = 0;
        n_chk++; if (reg_wen !== 1'b1) begin n_fail++; $display("FAIL waw_ex_wen: got %0h, expected 1", reg_wen); end
        n_chk++; if (reg_wdata !== 32'h99) begin n_fail++; $display("FAIL waw_ex_data: got %0h, expected 99", reg_wdata); end
        @(negedge clk);
    endtask

    task automatic test_errors_reset();
        ld_issue = 1; ld_rd = 3;
        @(negedge clk);
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_first_issue: got %0h, expected 0", err); end
        @(negedge clk);
        ld_issue = 0;
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_double_issue: got %0h, expected 1", err); end
        ex_valid = 1; ex_waddr = 2; ex_wdata = 32'h22;
        lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'h33;
        rst = 0;
        #1;
        n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ex_ready: got %0h, expected 0", ex_ready); end
        n_chk++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_lsu_ready: got %0h, expected 0", lsu_ready); end
        @(negedge clk);
        id_rs1 = 3;
        #1;
        n_chk++; if (reg_wen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wen: got %0h, expected 0", reg_wen); end
        n_chk++; if (reg_waddr !== 5'd0) begin n_fail++; $display("FAIL mid_rst_waddr: got %0h, expected 0", reg_waddr); end
        n_chk++; if (reg_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_rst_wdata: got %0h, expected 0", reg_wdata); end
        n_chk++; if (buf_count !== 2'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0h, expected 0", buf_count); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %0h, expected 0", err); end
        n_chk++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %0h, expected 0", id_stall); end
        rst = 1; ex_valid = 0; id_rs1 = 0;
        lsu_valid = 1; lsu_waddr = 12; lsu_wdata = 32'hC;
        @(negedge clk);
        lsu_valid = 0;
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_unmarked_load: got %0h, expected 1", err); end
        @(negedge clk);
        n_chk++; if (reg_waddr !== 5'd12) begin n_fail++; $display("FAIL unmarked_still_written: got %0h, expected c", reg_waddr); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_ex_only();
        test_load_path();
        test_contention();
        test_back_to_back();
        test_x0_waw();
        test_errors_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
